// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: shift-and-add unsigned multiplier controller that borrows
// an external ALU for its 32-bit additions.
// Ports:
//   Clock, Reset          clock (rising edge), async active-high reset
//   i_start               multiply request, honoured only while idle
//   i_multiplicand        operand A, captured on an accepted start
//   i_multiplier          operand B, captured on an accepted start
//   o_busy                high while stepping or completing
//   o_done                one-cycle pulse, o_product valid afterwards
//   o_product             32-bit result, held until the next accepted start
//   o_alu_a/o_alu_b       ALU operand drives
//   o_alu_fun_sel         ALU function select
//   o_alu_wf              ALU flag write enable
//   i_alu_out             ALU combinational result
//   i_alu_flags           ALU flags {Z,C,N,O}; not used for control
module alu_mul_sequencer #(
  parameter int unsigned N_BITS = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              i_start,
  input  logic [N_BITS-1:0] i_multiplicand,
  input  logic [N_BITS-1:0] i_multiplier,
  output logic              o_busy,
  output logic              o_done,
  output logic [31:0]       o_product,
  output logic [31:0]       o_alu_a,
  output logic [31:0]       o_alu_b,
  output logic [4:0]        o_alu_fun_sel,
  output logic              o_alu_wf,
  input  logic [31:0]       i_alu_out,
  input  logic [3:0]        i_alu_flags
);

  localparam int unsigned CNT_W = $clog2(N_BITS) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_STEP = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [4:0] FS_ADD  = 5'b10100;
  localparam logic [4:0] FS_IDLE = 5'b10000;

  logic [1:0]        r_state;
  logic [31:0]       r_acc;
  logic [31:0]       r_mcand;
  logic [N_BITS-1:0] r_mplier;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_product;
  logic              r_busy;
  logic              r_done;
  logic [31:0]       r_alu_a;
  logic [31:0]       r_alu_b;
  logic [4:0]        r_alu_fun_sel;
  logic              r_alu_wf;

  logic [1:0]        w_state_nxt;
  logic [31:0]       w_acc_nxt;
  logic [31:0]       w_mcand_nxt;
  logic [N_BITS-1:0] w_mplier_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [31:0]       w_product_nxt;
  logic              w_add_nxt;

  // Flags are informational only.
  logic w_unused;
  assign w_unused = ^i_alu_flags;

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt   = r_state;
    w_acc_nxt     = r_acc;
    w_mcand_nxt   = r_mcand;
    w_mplier_nxt  = r_mplier;
    w_cnt_nxt     = r_cnt;
    w_product_nxt = r_product;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_acc_nxt    = '0;
          w_mcand_nxt  = 32'(i_multiplicand);
          w_mplier_nxt = i_multiplier;
          w_cnt_nxt    = '0;
          w_state_nxt  = S_STEP;
        end
      end
      S_STEP: begin
        // ALU outputs already hold acc + mcand whenever the low multiplier bit is set.
        if (r_mplier[0]) w_acc_nxt = i_alu_out;
        w_mcand_nxt  = r_mcand << 1;
        w_mplier_nxt = r_mplier >> 1;
        w_cnt_nxt    = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(N_BITS - 1)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_product_nxt = r_acc;
        w_state_nxt   = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // ALU drive for the coming cycle: add only in a step with the low bit set.
    w_add_nxt = (w_state_nxt == S_STEP) && w_mplier_nxt[0];
  end

  // State, datapath and registered outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state       <= S_IDLE;
      r_acc         <= '0;
      r_mcand       <= '0;
      r_mplier      <= '0;
      r_cnt         <= '0;
      r_product     <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_fun_sel <= FS_IDLE;
      r_alu_wf      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_acc         <= w_acc_nxt;
      r_mcand       <= w_mcand_nxt;
      r_mplier      <= w_mplier_nxt;
      r_cnt         <= w_cnt_nxt;
      r_product     <= w_product_nxt;
      r_busy        <= (w_state_nxt != S_IDLE);
      r_done        <= (w_state_nxt == S_DONE);
      r_alu_a       <= w_add_nxt ? w_acc_nxt : '0;
      r_alu_b       <= w_add_nxt ? w_mcand_nxt : '0;
      r_alu_fun_sel <= w_add_nxt ? FS_ADD : FS_IDLE;
      r_alu_wf      <= w_add_nxt;
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_product     = r_product;
  assign o_alu_a       = r_alu_a;
  assign o_alu_b       = r_alu_b;
  assign o_alu_fun_sel = r_alu_fun_sel;
  assign o_alu_wf      = r_alu_wf;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a behavioural ALU beside it.
module tb_alu_mul_sequencer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        i_start;
  logic [15:0] i_multiplicand;
  logic [15:0] i_multiplier;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_product;
  logic [31:0] o_alu_a;
  logic [31:0] o_alu_b;
  logic [4:0]  o_alu_fun_sel;
  logic        o_alu_wf;
  logic [31:0] w_alu_out;
  logic [3:0]  w_alu_flags;

  int total = 0;
  int bad   = 0;

  always #5 Clock = ~Clock;

  // Behavioural ALU: only the 32-bit add function matters here.
  assign w_alu_out   = (o_alu_fun_sel == 5'b10100) ? (o_alu_a + o_alu_b) : 32'h0;
  assign w_alu_flags = 4'h0;

  alu_mul_sequencer #(.N_BITS(16)) dut (
    .Clock(Clock), .Reset(Reset), .i_start(i_start),
    .i_multiplicand(i_multiplicand), .i_multiplier(i_multiplier),
    .o_busy(o_busy), .o_done(o_done), .o_product(o_product),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_fun_sel(o_alu_fun_sel),
    .o_alu_wf(o_alu_wf), .i_alu_out(w_alu_out), .i_alu_flags(w_alu_flags)
  );

  // Issue one multiply from idle and observe 20 cycles (negedge k after the accept edge).
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                         output logic [31:0] wf_mask, output int done_at,
                         output int done_cnt, output int busy_cnt, output int pat_bad);
    wf_mask = '0; done_at = 0; done_cnt = 0; busy_cnt = 0; pat_bad = 0;
    @(negedge Clock);
    i_multiplicand = a; i_multiplier = b; i_start = 1'b1;
    @(posedge Clock);
    #1 i_start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge Clock);
      if (o_alu_wf) begin
        wf_mask[k-1] = 1'b1;
        if (o_alu_fun_sel !== 5'b10100) pat_bad++;
      end else if (o_alu_a !== 32'h0 || o_alu_b !== 32'h0 || o_alu_fun_sel !== 5'b10000) begin
        pat_bad++;
      end
      if (o_done) begin
        done_cnt++;
        if (done_at == 0) done_at = k;
      end
      if (o_busy) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; i_start = 1'b0; i_multiplicand = '0; i_multiplier = '0;
    #2;
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", o_busy); end
    total++; if (o_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", o_done); end
    total++; if (o_product !== 32'h0) begin bad++; $display("FAIL reset_product got=%h want=0", o_product); end
    total++; if ({o_alu_a, o_alu_b, o_alu_fun_sel, o_alu_wf} !== {32'h0, 32'h0, 5'b10000, 1'b0}) begin
      bad++; $display("FAIL reset_alu got a=%h b=%h fs=%b wf=%b want idle", o_alu_a, o_alu_b, o_alu_fun_sel, o_alu_wf);
    end
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] m; int d, dc, bc, pb;
    run_mul(16'd3, 16'd5, m, d, dc, bc, pb);
    total++; if (m !== 32'h5) begin bad++; $display("FAIL basic_wf_mask got=%h want=00000005", m); end
    total++; if (d !== 17) begin bad++; $display("FAIL basic_done_at got=%0d want=17", d); end
    total++; if (o_product !== 32'h0000000F) begin bad++; $display("FAIL basic_product got=%h want=0000000f", o_product); end
    total++; if (pb !== 0) begin bad++; $display("FAIL basic_alu_pattern got=%0d bad cycles want=0", pb); end
  endtask

  task automatic test_max();
    logic [31:0] m; int d, dc, bc, pb;
    run_mul(16'hFFFF, 16'hFFFF, m, d, dc, bc, pb);
    total++; if (m !== 32'h0000FFFF) begin bad++; $display("FAIL max_wf_mask got=%h want=0000ffff", m); end
    total++; if (o_product !== 32'hFFFE0001) begin bad++; $display("FAIL max_product got=%h want=fffe0001", o_product); end
    total++; if (bc !== 17) begin bad++; $display("FAIL max_busy_cycles got=%0d want=17", bc); end
    total++; if (dc !== 1) begin bad++; $display("FAIL max_done_count got=%0d want=1", dc); end
  endtask

  task automatic test_zero();
    logic [31:0] m; int d, dc, bc, pb;
    run_mul(16'h1234, 16'h0000, m, d, dc, bc, pb);
    total++; if (m !== 32'h0) begin bad++; $display("FAIL zero_wf_mask got=%h want=0", m); end
    total++; if (pb !== 0) begin bad++; $display("FAIL zero_alu_pattern got=%0d bad cycles want=0", pb); end
    total++; if (o_product !== 32'h0) begin bad++; $display("FAIL zero_product got=%h want=0", o_product); end
    total++; if (d !== 17) begin bad++; $display("FAIL zero_done_at got=%0d want=17", d); end
  endtask

  task automatic test_ignore_start();
    int dc, d;
    dc = 0; d = 0;
    @(negedge Clock);
    i_multiplicand = 16'd2; i_multiplier = 16'd9; i_start = 1'b1;
    @(posedge Clock);
    #1 i_start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge Clock);
      if (k == 5) begin i_multiplicand = 16'd7; i_multiplier = 16'd7; i_start = 1'b1; end
      if (k == 6) i_start = 1'b0;
      if (o_done) begin dc++; if (d == 0) d = k; end
    end
    total++; if (dc !== 1) begin bad++; $display("FAIL ignore_done_count got=%0d want=1", dc); end
    total++; if (d !== 17) begin bad++; $display("FAIL ignore_done_at got=%0d want=17", d); end
    total++; if (o_product !== 32'h00000012) begin bad++; $display("FAIL ignore_product got=%h want=00000012", o_product); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] m; int d, dc, bc, pb;
    @(negedge Clock);
    i_multiplicand = 16'h00FF; i_multiplier = 16'h00FF; i_start = 1'b1;
    @(posedge Clock);
    #1 i_start = 1'b0;
    repeat (8) @(negedge Clock);
    total++; if (o_alu_wf !== 1'b1) begin bad++; $display("FAIL abort_pre_wf got=%b want=1", o_alu_wf); end
    Reset = 1'b1;
    #1;
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", o_busy); end
    total++; if (o_product !== 32'h0) begin bad++; $display("FAIL abort_product got=%h want=0", o_product); end
    total++; if ({o_alu_a, o_alu_b, o_alu_fun_sel, o_alu_wf} !== {32'h0, 32'h0, 5'b10000, 1'b0}) begin
      bad++; $display("FAIL abort_alu got a=%h b=%h fs=%b wf=%b want idle", o_alu_a, o_alu_b, o_alu_fun_sel, o_alu_wf);
    end
    repeat (3) @(negedge Clock);
    total++; if (o_done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want=0", o_done); end
    Reset = 1'b0;
    run_mul(16'h00FF, 16'h00FF, m, d, dc, bc, pb);
    total++; if (o_product !== 32'h0000FE01) begin bad++; $display("FAIL abort_rerun_product got=%h want=0000fe01", o_product); end
    total++; if (d !== 17) begin bad++; $display("FAIL abort_rerun_done_at got=%0d want=17", d); end
  endtask

  task automatic test_back_to_back();
    int dc, first, prev, last_done;
    dc = 0; first = 0; prev = 0; last_done = 0;
    @(negedge Clock);
    i_multiplicand = 16'd10; i_multiplier = 16'd10; i_start = 1'b1;
    @(posedge Clock);
    for (int k = 1; k <= 60; k++) begin
      @(negedge Clock);
      if (last_done == k - 1 && last_done != 0) begin
        total++; if (o_product !== 32'h00000064) begin bad++; $display("FAIL b2b_product got=%h want=00000064 at k=%0d", o_product, k); end
      end
      if (o_done) begin
        dc++;
        if (first == 0) first = k;
        if (prev != 0) begin
          total++; if (k - prev !== 18) begin bad++; $display("FAIL b2b_interval got=%0d want=18", k - prev); end
        end
        prev = k;
        last_done = k;
      end
    end
    i_start = 1'b0;
    total++; if (first !== 17) begin bad++; $display("FAIL b2b_first_done got=%0d want=17", first); end
    total++; if (dc !== 3) begin bad++; $display("FAIL b2b_done_count got=%0d want=3", dc); end
    repeat (20) @(negedge Clock);
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL b2b_final_busy got=%b want=0", o_busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
